immediate_encoder: RTL and testbench
====================================

# immediate_encoder

Constant-synthesis encoder for the 32-bit MIPS core, and the inverse of the 16→32 sign-extend datapath. It accepts a 32-bit constant and a destination register and emits the shortest MIPS instruction sequence that loads that constant. The sequence is one or two instructions: ADDIU, ORI, LUI, or LUI+ORI. It sits between the constant/boot-loader front end and the instruction memory write port, with valid/ready handshakes on both sides.

## Interface
- ALLOW_SINGLE, 1, when 1 emit the shortest sequence; when 0 always emit the fixed-length LUI+ORI pair, for patchable slots.
- CLK  input  1  clock; all state changes on the rising edge.
- RST_N  input  1  asynchronous reset, active-low.
- IN_VALID  input  1  VALUE/RT are valid.
- IN_READY  output  1  block can accept a constant; equals (state == IDLE).
- VALUE  input  32  constant to synthesize.
- RT  input  5  destination register number.
- OUT_VALID  output  1  INSTR holds a valid instruction word.
- OUT_READY  input  1  consumer takes INSTR.
- INSTR  output  32  encoded instruction word, registered.
- LAST  output  1  INSTR is the final word of the current sequence.

## Operation
- Acceptance occurs on a rising edge with IN_VALID && IN_READY. VALUE and RT are captured into internal registers.
- Classification, first match wins, with lo = VALUE[15:0] and hi = VALUE[31:16]:
  - SEXT: VALUE[31:15] all equal. Emit ADDIU rt,$0,lo = {6'b001001, 5'd0, rt, lo}.
  - ZEXT: hi == 0. Emit ORI rt,$0,lo = {6'b001101, 5'd0, rt, lo}.
  - HIONLY: lo == 0. Emit LUI rt,hi = {6'b001111, 5'd0, rt, hi}.
  - FULL: otherwise. Emit LUI rt,hi, then ORI rt,rt,lo = {6'b001101, rt, rt, lo}.
- When ALLOW_SINGLE=0, every constant is treated as FULL, including lo == 0. ORI with imm 0 is still emitted.
- RT = 0 gets no special case; it is encoded as given.
- The state machine has three states: IDLE, EMIT_HI and EMIT_LAST.
  - IDLE + accept, FULL → EMIT_HI. INSTR = LUI, LAST = 0.
  - IDLE + accept, other class → EMIT_LAST. INSTR = the single word, LAST = 1.
  - EMIT_HI + OUT_READY → EMIT_LAST. INSTR = ORI rt,rt,lo, LAST = 1.
  - EMIT_LAST + OUT_READY → IDLE. OUT_VALID = 0.
  - EMIT_* + !OUT_READY → hold. INSTR, LAST and OUT_VALID stay stable.
- OUT_VALID = (state != IDLE), registered.
- IN_VALID is ignored outside IDLE. No input is queued.

## Timing
- Reset, asynchronous and immediate: state = IDLE, OUT_VALID = 0, INSTR = 32'h0, LAST = 0, IN_READY = 1.
- Latency: a constant accepted at edge k has its first word valid in the cycle after edge k.
- Within a FULL sequence the ORI follows the LUI handshake with no bubble.
- After the LAST handshake there is one IDLE cycle, so IN_READY is high in the next cycle.
- Peak throughput: 1 word per cycle inside a sequence, plus 1 idle cycle per constant.
- If reset is asserted mid-sequence, the pending word is discarded: no ORI is emitted after a LUI that was already taken. After deassertion the block is in IDLE.
- OUT_READY held high continuously is legal; words stream at 1 per cycle.
- OUT_READY asserted while OUT_VALID = 0 has no effect.

## Structure
- Shared package mips_isa_pkg holds:
  - the opcode constants OPC_ADDIU = 6'b001001, OPC_ORI = 6'b001101 and OPC_LUI = 6'b001111;
  - REG_ZERO = 5'd0;
  - the encoder state encoding: IDLE, EMIT_HI, EMIT_LAST.
- One combinational sub-module, imm_classify, takes VALUE and ALLOW_SINGLE and outputs the class: SEXT, ZEXT, HIONLY or FULL. Its class encoding also lives in mips_isa_pkg.
- The top level holds the state machine, the captured registers, the word mux and the output register.

## Test plan
- VALUE=0x00002FBD, RT=8 → one word 0x24082FBD with LAST=1; IN_READY is high again 2 cycles after acceptance.
- VALUE=0xFFFF8000, RT=9 → 0x24098000 (ADDIU). VALUE=0x00008000, RT=10 → 0x340A8000 (ORI, not ADDIU).
- VALUE=0x12345678, RT=4, with OUT_READY low for 3 cycles:
  - 0x3C041234 with LAST=0 is held stable for those cycles;
  - then 0x34845678 with LAST=1 follows on the next cycle after the handshake.
- VALUE=0x00010000, RT=2 → single 0x3C020001, LAST=1. With ALLOW_SINGLE=0, VALUE=0x00000005, RT=3 → 0x3C030000, then 0x34630005.
- IN_VALID held high with new constants during an emitting sequence → IN_READY=0 and no capture; the next constant is taken only in IDLE.
- Start VALUE=0x12345678, take the LUI, then pull RST_N low mid-cycle → OUT_VALID drops immediately and INSTR = 0. After release, IN_READY=1 and no ORI appears.

Source files
------------

// File: rtl/mips_isa_pkg.sv
// Shared MIPS I-type encoding constants and encoder state/class types.
// Imported by the immediate encoder and its classifier.
package mips_isa_pkg;

    localparam logic [5:0] OPC_ADDIU = 6'b001001;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_LUI   = 6'b001111;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        IDLE,
        EMIT_HI,
        EMIT_LAST
    } enc_state_e;

    typedef enum logic [1:0] {
        CLS_SEXT,
        CLS_ZEXT,
        CLS_HIONLY,
        CLS_FULL
    } imm_class_e;

    function automatic logic [31:0] itype(
        input logic [5:0]  opc,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [15:0] imm
    );
        return {opc, rs, rt, imm};
    endfunction

endpackage

// File: rtl/imm_classify.sv
// Picks the shortest load-constant form for a 32-bit value.
// With allow_single low every value is forced to the LUI+ORI pair.
import mips_isa_pkg::*;

module imm_classify (
    input  logic [31:0] value,
    input  logic        allow_single,
    output imm_class_e  cls
);

    logic sext;
    logic zext;
    logic hionly;

    // bits 31..15 identical means ADDIU's sign extension reproduces it
    assign sext   = (&value[31:15]) | ~(|value[31:15]);
    assign zext   = ~(|value[31:16]);
    assign hionly = ~(|value[15:0]);

    always_comb begin
        cls = CLS_FULL;
        if (!allow_single)
            cls = CLS_FULL;
        else if (sext)
            cls = CLS_SEXT;
        else if (zext)
            cls = CLS_ZEXT;
        else if (hionly)
            cls = CLS_HIONLY;
    end

endmodule

// File: rtl/immediate_encoder.sv
// Emits ADDIU / ORI / LUI / LUI+ORI words that load a 32-bit constant.
// Valid/ready on both sides; one idle cycle separates constants.
import mips_isa_pkg::*;

module immediate_encoder #(
    parameter bit ALLOW_SINGLE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] value,
    input  logic [4:0]  rt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic        last
);

    enc_state_e  state;
    imm_class_e  cls;
    logic [4:0]  rt_q;
    logic [15:0] lo_q;
    logic [31:0] first_word;

    imm_classify u_classify (
        .value        (value),
        .allow_single (ALLOW_SINGLE),
        .cls          (cls)
    );

    assign in_ready = (state == IDLE);

    always_comb begin
        first_word = itype(OPC_LUI, REG_ZERO, rt, value[31:16]);
        case (cls)
            CLS_SEXT:
                first_word = itype(OPC_ADDIU, REG_ZERO, rt, value[15:0]);
            CLS_ZEXT:
                first_word = itype(OPC_ORI, REG_ZERO, rt, value[15:0]);
            default:
                first_word = itype(OPC_LUI, REG_ZERO, rt, value[31:16]);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            instr     <= 32'h0;
            last      <= 1'b0;
            rt_q      <= 5'd0;
            lo_q      <= 16'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        rt_q      <= rt;
                        lo_q      <= value[15:0];
                        instr     <= first_word;
                        out_valid <= 1'b1;
                        if (cls == CLS_FULL) begin
                            state <= EMIT_HI;
                            last  <= 1'b0;
                        end else begin
                            state <= EMIT_LAST;
                            last  <= 1'b1;
                        end
                    end
                end
                EMIT_HI: begin
                    if (out_ready) begin
                        instr <= itype(OPC_ORI, rt_q, rt_q, lo_q);
                        last  <= 1'b1;
                        state <= EMIT_LAST;
                    end
                end
                EMIT_LAST: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        last      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    last      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_immediate_encoder.sv
// Randomized bench for immediate_encoder against an arithmetic model.
// Instance a uses shortest sequences, instance b the fixed pair.
module tb_immediate_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid_a = 1'b0;
    logic        in_valid_b = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] value = 32'h0;
    logic [4:0]  rt = 5'd0;

    logic        in_ready_a, out_valid_a, last_a;
    logic        in_ready_b, out_valid_b, last_b;
    logic [31:0] instr_a, instr_b;

    int sel = 0;
    int n_cmp = 0;
    int n_bad = 0;

    logic        o_ready, o_valid, o_last;
    logic [31:0] o_instr;

    always #5 clk = ~clk;

    immediate_encoder #(.ALLOW_SINGLE(1'b1)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_a),
        .in_ready  (in_ready_a),
        .value     (value),
        .rt        (rt),
        .out_valid (out_valid_a),
        .out_ready (out_ready),
        .instr     (instr_a),
        .last      (last_a)
    );

    immediate_encoder #(.ALLOW_SINGLE(1'b0)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .value     (value),
        .rt        (rt),
        .out_valid (out_valid_b),
        .out_ready (out_ready),
        .instr     (instr_b),
        .last      (last_b)
    );

    assign o_ready = (sel != 0) ? in_ready_b  : in_ready_a;
    assign o_valid = (sel != 0) ? out_valid_b : out_valid_a;
    assign o_last  = (sel != 0) ? last_b      : last_a;
    assign o_instr = (sel != 0) ? instr_b     : instr_a;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc(input int opc, input int rs,
                                        input int rd, input int imm);
        int w;
        w = opc * 67108864 + rs * 2097152 + rd * 65536 + imm;
        return 32'(w);
    endfunction

    // Reference: choose the load-constant idiom from the numeric value
    task automatic model(input bit allow, input logic [31:0] v,
                         input logic [4:0] r, output int n,
                         output logic [31:0] w0, output logic [31:0] w1);
        int sv, lo, hi, rd;
        sv = $signed(v);
        lo = int'(v % 32'h10000);
        hi = int'(v / 32'h10000);
        rd = int'(r);
        w1 = 32'h0;
        if (allow && sv >= -32768 && sv <= 32767) begin
            n = 1;
            w0 = enc(9, 0, rd, lo);
        end else if (allow && hi == 0) begin
            n = 1;
            w0 = enc(13, 0, rd, lo);
        end else if (allow && lo == 0) begin
            n = 1;
            w0 = enc(15, 0, rd, hi);
        end else begin
            n = 2;
            w0 = enc(15, 0, rd, hi);
            w1 = enc(13, rd, rd, lo);
        end
    endtask

    task automatic drive_valid(input bit x);
        in_valid_a = (sel == 0) && x;
        in_valid_b = (sel != 0) && x;
    endtask

    task automatic run(input int s, input logic [31:0] v, input logic [4:0] r,
                       input int stall, input bit hog);
        int n, st;
        logic [31:0] w0, w1, w;
        logic lst;
        sel = s;
        model(s == 0, v, r, n, w0, w1);
        @(negedge clk);
        check("idle_ready", o_ready, 1);
        value = v;
        rt = r;
        out_ready = 1'b0;
        drive_valid(1'b1);
        @(negedge clk);
        if (hog) begin
            value = $urandom;
            rt = 5'($urandom);
        end else begin
            drive_valid(1'b0);
        end
        for (int i = 0; i < n; i++) begin
            w = (i == 0) ? w0 : w1;
            lst = (i == n - 1);
            st = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
            repeat (st) begin
                check("hold_valid", o_valid, 1);
                check("hold_instr", o_instr, w);
                check("hold_last", o_last, lst);
                check("busy_ready", o_ready, 0);
                @(negedge clk);
                if (hog) value = $urandom;
            end
            check("word_valid", o_valid, 1);
            check("word_instr", o_instr, w);
            check("word_last", o_last, lst);
            check("word_ready", o_ready, 0);
            out_ready = 1'b1;
            if (lst) drive_valid(1'b0);
            @(negedge clk);
            out_ready = 1'b0;
        end
        check("done_valid", o_valid, 0);
        check("done_ready", o_ready, 1);
    endtask

    initial begin
        int n;
        logic [31:0] w0, w1, v;
        int mode, t;

        #2;
        check("rst_valid", out_valid_a, 0);
        check("rst_instr", instr_a, 32'h0);
        check("rst_last", last_a, 0);
        check("rst_ready", in_ready_a, 1);
        check("rst_valid_b", out_valid_b, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run(0, 32'h00002FBD, 5'd8, 0, 1'b0);
        run(0, 32'hFFFF8000, 5'd9, 0, 1'b0);
        run(0, 32'h00008000, 5'd10, 0, 1'b0);
        run(0, 32'h12345678, 5'd4, 3, 1'b0);
        run(0, 32'h00010000, 5'd2, 0, 1'b0);
        run(0, 32'h00000000, 5'd0, 0, 1'b0);
        run(0, 32'h00007FFF, 5'd31, 1, 1'b0);
        run(0, 32'hFFFF7FFF, 5'd1, 1, 1'b0);
        run(1, 32'h00000005, 5'd3, 0, 1'b0);
        run(1, 32'h00010000, 5'd7, 0, 1'b0);
        run(0, 32'hDEADBEEF, 5'd12, 2, 1'b1);
        run(0, 32'h00001234, 5'd13, 2, 1'b1);

        for (int k = 0; k < 300; k++) begin
            mode = int'($urandom_range(0, 4));
            v = $urandom;
            case (mode)
                1: begin
                    t = int'($urandom_range(0, 65535)) - 32768;
                    v = 32'(t);
                end
                2: v = v % 32'h10000;
                3: v = v - (v % 32'h10000);
                default: v = $urandom;
            endcase
            run(k % 2, v, 5'($urandom), -1, 1'($urandom));
        end

        // Reset after the LUI was taken must drop the pending ORI
        sel = 0;
        model(1'b1, 32'h12345678, 5'd4, n, w0, w1);
        @(negedge clk);
        value = 32'h12345678;
        rt = 5'd4;
        drive_valid(1'b1);
        @(negedge clk);
        drive_valid(1'b0);
        check("rst_lui", o_instr, w0);
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        out_ready = 1'b0;
        #1;
        check("mid_rst_valid", o_valid, 0);
        check("mid_rst_instr", o_instr, 32'h0);
        check("mid_rst_last", o_last, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_valid", o_valid, 0);
            check("post_rst_ready", o_ready, 1);
        end
        out_ready = 1'b0;

        run(0, 32'hCAFE0000, 5'd5, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
